// File: rtl/status_reg_if.sv
// Peripheral bus access port of the USRT configuration/status register.
// The master drives the access strobe and write data; the slave returns read data.
interface status_reg_if;
   logic       i_Enable;
   logic       i_Pwrite;
   logic [7:0] i_Data;
   logic       o_Enable;
   logic [7:0] o_Data;

   modport master (
      output i_Enable, i_Pwrite, i_Data,
      input  o_Enable, o_Data
   );

   modport slave (
      input  i_Enable, i_Pwrite, i_Data,
      output o_Enable, o_Data
   );
endinterface

// File: rtl/status_reg.sv
// USRT configuration/status register: one 8-bit control byte on the peripheral bus,
// with parity, stop-bit and baud-divider fields decoded for the TX/RX engines.
module status_reg #(
   parameter int CLK_HZ = 10_000_000,
   parameter int DIV_W  = 16
) (
   input  logic             i_Pclk,
   input  logic             i_Reset,
   status_reg_if.slave      bus,
   output logic             o_ParityEn,
   output logic             o_ParityOdd,
   output logic             o_TwoStop,
   output logic [DIV_W-1:0] o_BaudDiv
);

   // Quotient clamped into DIV_W bits; a zero divider would stall the bit timer.
   function automatic logic [DIV_W-1:0] div_sat(input longint baud);
      longint q;
      longint max_q;
      q     = longint'(CLK_HZ) / baud;
      max_q = (64'sd1 <<< DIV_W) - 64'sd1;
      if (q > max_q)
         div_sat = '1;
      else if (q < 64'sd1)
         div_sat = DIV_W'(1);
      else
         div_sat = q[DIV_W-1:0];
   endfunction

   localparam logic [DIV_W-1:0] DIV_4800  = div_sat(4800);
   localparam logic [DIV_W-1:0] DIV_9600  = div_sat(9600);
   localparam logic [DIV_W-1:0] DIV_19200 = div_sat(19200);
   localparam logic [DIV_W-1:0] DIV_38400 = div_sat(38400);

   logic [7:0] ctrl;
   logic       wr;
   logic       rd;

   assign wr = bus.i_Enable &  bus.i_Pwrite;
   assign rd = bus.i_Enable & ~bus.i_Pwrite;

   // Bus access stage: reserved bits are masked so they always read back as zero.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         ctrl         <= 8'h00;
         bus.o_Data   <= 8'h00;
         bus.o_Enable <= 1'b0;
      end else begin
         bus.o_Enable <= rd;
         if (wr)
            ctrl <= bus.i_Data & 8'h1F;
         if (rd)
            bus.o_Data <= ctrl;
      end
   end

   // Field decode straight off the stored byte, so fields follow the write edge.
   always_comb begin
      o_ParityEn  = ctrl[0];
      o_ParityOdd = ctrl[1];
      o_TwoStop   = ctrl[4];
      case (ctrl[3:2])
         2'b00:   o_BaudDiv = DIV_4800;
         2'b01:   o_BaudDiv = DIV_9600;
         2'b10:   o_BaudDiv = DIV_19200;
         default: o_BaudDiv = DIV_38400;
      endcase
   end

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed scenarios with literal expectations
// plus randomized bus traffic compared every cycle against a behavioural model.
module tb_status_reg;
   localparam int CLK_HZ = 10_000_000;
   localparam int DIV_W  = 16;

   logic             clk;
   logic             rst;
   logic             pen;
   logic             podd;
   logic             two;
   logic [DIV_W-1:0] bdiv;

   status_reg_if bus ();

   status_reg #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
      .i_Pclk      (clk),
      .i_Reset     (rst),
      .bus         (bus),
      .o_ParityEn  (pen),
      .o_ParityOdd (podd),
      .o_TwoStop   (two),
      .o_BaudDiv   (bdiv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Behavioural model: the stored byte, the last read value and the read strobe.
   logic [7:0] m_reg;
   logic [7:0] m_data;
   logic       m_en;
   logic       m_valid = 1'b0;

   function automatic longint exp_div(input logic [1:0] sel);
      longint rates [4];
      longint q;
      rates = '{4800, 9600, 19200, 38400};
      q = CLK_HZ / rates[sel];
      if (q > (2 ** DIV_W) - 1) q = (2 ** DIV_W) - 1;
      if (q < 1) q = 1;
      return q;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_reg   <= 8'h00;
         m_data  <= 8'h00;
         m_en    <= 1'b0;
         m_valid <= 1'b1;
      end else begin
         m_en <= bus.i_Enable && !bus.i_Pwrite;
         if (bus.i_Enable && bus.i_Pwrite) m_reg <= {3'b000, bus.i_Data[4:0]};
         if (bus.i_Enable && !bus.i_Pwrite) m_data <= m_reg;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_o_Enable", bus.o_Enable, m_en);
         chk("model_o_Data", bus.o_Data, m_data);
         chk("model_ParityEn", pen, m_reg[0]);
         chk("model_ParityOdd", podd, m_reg[1]);
         chk("model_TwoStop", two, m_reg[4]);
         chk("model_BaudDiv", bdiv, exp_div(m_reg[3:2]));
      end
   end

   task automatic cyc(input logic en, input logic pw, input logic [7:0] d, input logic r);
      @(negedge clk);
      bus.i_Enable = en;
      bus.i_Pwrite = pw;
      bus.i_Data   = d;
      rst          = r;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.i_Enable = 1'b0;
      bus.i_Pwrite = 1'b0;
      bus.i_Data   = 8'h00;
      rst          = 1'b1;
      repeat (2) @(posedge clk);

      // Reset then read
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("reset_o_Enable", bus.o_Enable, 0);
      chk("reset_o_Data", bus.o_Data, 0);
      chk("reset_BaudDiv", bdiv, 2083);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("rd0_o_Enable", bus.o_Enable, 1);
      chk("rd0_o_Data", bus.o_Data, 8'h00);
      chk("rd0_BaudDiv", bdiv, 2083);
      chk("rd0_ParityEn", pen, 0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("rd0_pulse_end", bus.o_Enable, 0);

      // Write 0x0D, idle, read
      cyc(1'b1, 1'b1, 8'h0D, 1'b0);
      repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("rd0D_o_Data", bus.o_Data, 8'h0D);
      chk("rd0D_o_Enable", bus.o_Enable, 1);
      chk("rd0D_BaudDiv", bdiv, 260);
      chk("rd0D_ParityEn", pen, 1);
      chk("rd0D_ParityOdd", podd, 0);
      chk("rd0D_TwoStop", two, 0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("rd0D_pulse_end", bus.o_Enable, 0);

      // Write 0xFF: reserved bits dropped
      cyc(1'b1, 1'b1, 8'hFF, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("rdFF_o_Data", bus.o_Data, 8'h1F);
      chk("rdFF_TwoStop", two, 1);
      chk("rdFF_ParityOdd", podd, 1);
      chk("rdFF_BaudDiv", bdiv, 260);

      // Write 0x04 then immediate read
      cyc(1'b1, 1'b1, 8'h04, 1'b0);
      after_edge();
      chk("wr04_o_Enable", bus.o_Enable, 0);
      chk("wr04_BaudDiv", bdiv, 1041);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("rd04_o_Data", bus.o_Data, 8'h04);
      chk("rd04_o_Enable", bus.o_Enable, 1);

      // Reset dominates a simultaneous write
      cyc(1'b1, 1'b1, 8'h0D, 1'b1);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("rstwr_o_Data", bus.o_Data, 8'h00);
      chk("rstwr_BaudDiv", bdiv, 2083);

      // Write 0x19, read, then activity with the strobe low must not disturb anything
      cyc(1'b1, 1'b1, 8'h19, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, i[0], 8'(8'hA5 ^ i), 1'b0);
      after_edge();
      chk("idle_o_Data", bus.o_Data, 8'h19);
      chk("idle_o_Enable", bus.o_Enable, 0);
      chk("idle_BaudDiv", bdiv, 520);
      chk("idle_TwoStop", two, 1);
      repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      after_edge();
      chk("hold_o_Data", bus.o_Data, 8'h19);

      // Randomized traffic; the model comparison runs every cycle
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
             ($urandom_range(0, 99) == 0));
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
